// File: rtl/wb_regfile_if.sv
// MEM/WB write-back and decode read-port bundle for wb_regfile.
// Master drives the pipeline/decode side; slave is the register file.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              en;
  logic [ADDR_W-1:0] rd_addr_w;
  logic              rd_wr_w;
  logic              wb_sel_w;
  logic [DATA_W-1:0] alu_data_w;
  logic [DATA_W-1:0] ld_data_w;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_commit;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output en, rd_addr_w, rd_wr_w, wb_sel_w, alu_data_w, ld_data_w,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, wb_commit, wb_count
  );

  modport slave (
    input  en, rd_addr_w, rd_wr_w, wb_sel_w, alu_data_w, ld_data_w,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, wb_commit, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects WB data, commits it to the integer register file,
// serves two combinational read ports. WB_REGFILE_BYPASS_EN adds write-through.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst,
  wb_regfile_if.slave    bus
);

  // Entry 0 has no storage; it is synthesised as a constant zero on reads.
  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic [DATA_W-1:0] wb_data_c;
  logic              wb_commit_c;
  logic [DATA_W-1:0] rs1_c;
  logic [DATA_W-1:0] rs2_c;

  always_comb begin
    wb_data_c   = bus.wb_sel_w ? bus.ld_data_w : bus.alu_data_w;
    wb_commit_c = bus.en & bus.rd_wr_w & (bus.rd_addr_w != '0);
  end

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wb_commit_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wb_commit_c && (bus.rd_addr_w == ADDR_W'(i))) begin
        regs_d[i] = wb_data_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rs1_c = '0;
    rs2_c = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (bus.rs1_addr == ADDR_W'(i)) rs1_c = regs_q[i];
      if (bus.rs2_addr == ADDR_W'(i)) rs2_c = regs_q[i];
    end
`ifdef WB_REGFILE_BYPASS_EN
    // wb_commit_c already excludes x0, so bypass can never expose a nonzero x0.
    if (wb_commit_c && (bus.rs1_addr == bus.rd_addr_w)) rs1_c = wb_data_c;
    if (wb_commit_c && (bus.rs2_addr == bus.rd_addr_w)) rs2_c = wb_data_c;
`else
    // Same-cycle reads return the old value; the forwarding unit uses wb_data.
`endif
  end

  assign bus.wb_data   = wb_data_c;
  assign bus.wb_commit = wb_commit_c;
  assign bus.rs1_data  = rs1_c;
  assign bus.rs2_data  = rs2_c;
  assign bus.wb_count  = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table, corner sequences,
// randomized traffic against an array model, and a 4-bit counter wrap.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

  wb_regfile #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  wb_regfile #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  typedef struct packed {
    logic        en;
    logic        wr;
    logic [4:0]  addr;
    logic        sel;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_wb;
    logic        exp_commit;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic [31:0] exp_cnt;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic wr, input logic [4:0] addr,
                       input logic sel, input logic [31:0] alu, input logic [31:0] ld,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    bus.en = en; bus.rd_wr_w = wr; bus.rd_addr_w = addr; bus.wb_sel_w = sel;
    bus.alu_data_w = alu; bus.ld_data_w = ld; bus.rs1_addr = rs1; bus.rs2_addr = rs2;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] wbd;
    logic        cm;
    wbd = bus.wb_sel_w ? bus.ld_data_w : bus.alu_data_w;
    cm  = bus.en && bus.rd_wr_w && (bus.rd_addr_w != 5'd0);
    if (a == 5'd0) return 32'd0;
    if (BYP && cm && (a == bus.rd_addr_w)) return wbd;
    return m_regs[a];
  endfunction

  // One randomized cycle: compare combinational outputs, clock, update model.
  task automatic rand_cycle();
    logic [31:0] wbd;
    logic        cm;
    logic [4:0]  a;
    a = 5'($urandom_range(0, 31));
    drive(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), a,
          1'($urandom_range(0, 1)), $urandom, $urandom,
          ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
          ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)));
    #3;
    wbd = bus.wb_sel_w ? bus.ld_data_w : bus.alu_data_w;
    cm  = bus.en && bus.rd_wr_w && (bus.rd_addr_w != 5'd0);
    chk("rand_wb_data", {32'd0, bus.wb_data}, {32'd0, wbd});
    chk("rand_wb_commit", {63'd0, bus.wb_commit}, {63'd0, cm});
    chk("rand_rs1", {32'd0, bus.rs1_data}, {32'd0, m_read(bus.rs1_addr)});
    chk("rand_rs2", {32'd0, bus.rs2_data}, {32'd0, m_read(bus.rs2_addr)});
    @(posedge clk); #1;
    if (cm) begin
      m_regs[bus.rd_addr_w] = wbd;
      m_cnt = m_cnt + 32'd1;
    end
    chk("rand_count", {32'd0, bus.wb_count}, {32'd0, m_cnt});
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd3,  1'b0, 32'hDEADBEEF, 32'h11111111, 5'd0,  5'd3,
                32'hDEADBEEF, 1'b1, 32'h0,        32'hDEADBEEF, 32'd1};
    vecs[1] = '{1'b1, 1'b1, 5'd4,  1'b1, 32'h00000000, 32'h11111111, 5'd4,  5'd3,
                32'h11111111, 1'b1, 32'h11111111, 32'hDEADBEEF, 32'd2};
    vecs[2] = '{1'b1, 1'b1, 5'd0,  1'b0, 32'hFFFFFFFF, 32'h0,        5'd0,  5'd0,
                32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        32'd2};
    vecs[3] = '{1'b0, 1'b1, 5'd7,  1'b0, 32'hA5A5A5A5, 32'h0,        5'd7,  5'd3,
                32'hA5A5A5A5, 1'b0, 32'h0,        32'hDEADBEEF, 32'd2};
    vecs[4] = '{1'b1, 1'b0, 5'd7,  1'b0, 32'h12345678, 32'h0,        5'd7,  5'd4,
                32'h12345678, 1'b0, 32'h0,        32'h11111111, 32'd2};
    vecs[5] = '{1'b1, 1'b1, 5'd12, 1'b0, 32'hCAFEF00D, 32'h0,        5'd12, 5'd12,
                32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 32'd3};
    vecs[6] = '{1'b1, 1'b1, 5'd9,  1'b0, 32'h00000001, 32'h0,        5'd9,  5'd9,
                32'h00000001, 1'b1, 32'h1,        32'h1,        32'd4};

    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd5, 5'd31);
    bus4.en = 1'b0; bus4.rd_wr_w = 1'b0; bus4.rd_addr_w = 5'd0; bus4.wb_sel_w = 1'b0;
    bus4.alu_data_w = 32'd0; bus4.ld_data_w = 32'd0; bus4.rs1_addr = 5'd0; bus4.rs2_addr = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rs1", {32'd0, bus.rs1_data}, 64'd0);
    chk("reset_rs2", {32'd0, bus.rs2_data}, 64'd0);
    chk("reset_count", {32'd0, bus.wb_count}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].sel, vecs[i].alu,
            vecs[i].ld, vecs[i].rs1, vecs[i].rs2);
      #3;
      chk($sformatf("vec%0d_wb_data", i), {32'd0, bus.wb_data}, {32'd0, vecs[i].exp_wb});
      chk($sformatf("vec%0d_commit", i), {63'd0, bus.wb_commit}, {63'd0, vecs[i].exp_commit});
      @(posedge clk); #1;
      bus.en = 1'b0;
      #1;
      chk($sformatf("vec%0d_rs1", i), {32'd0, bus.rs1_data}, {32'd0, vecs[i].exp_rs1});
      chk($sformatf("vec%0d_rs2", i), {32'd0, bus.rs2_data}, {32'd0, vecs[i].exp_rs2});
      chk($sformatf("vec%0d_count", i), {32'd0, bus.wb_count}, {32'd0, vecs[i].exp_cnt});
      @(posedge clk); #1;
    end

    // Same-cycle write/read of x9: old 0x1, new 0x2
    drive(1'b1, 1'b1, 5'd9, 1'b0, 32'h2, 32'h0, 5'd9, 5'd0);
    #3;
    chk("rdw9_before", {32'd0, bus.rs1_data}, BYP ? 64'h2 : 64'h1);
    chk("rdw9_x0", {32'd0, bus.rs2_data}, 64'd0);
    @(posedge clk); #1;
    bus.en = 1'b0;
    #1;
    chk("rdw9_after", {32'd0, bus.rs1_data}, 64'h2);

    // Read x12 while writing x13
    drive(1'b1, 1'b1, 5'd13, 1'b1, 32'h0, 32'h00000077, 5'd12, 5'd13);
    #3;
    chk("dual_rs1_stored", {32'd0, bus.rs1_data}, 64'hCAFEF00D);
    chk("dual_rs2_new", {32'd0, bus.rs2_data}, BYP ? 64'h77 : 64'h0);
    @(posedge clk); #1;
    chk("dual_count", {32'd0, bus.wb_count}, 64'd6);

    // Asynchronous reset mid-cycle after x5 = 0x1234
    drive(1'b1, 1'b1, 5'd5, 1'b0, 32'h1234, 32'h0, 5'd5, 5'd9);
    @(posedge clk); #1;
    bus.en = 1'b0;
    #1;
    chk("pre_rst_x5", {32'd0, bus.rs1_data}, 64'h1234);
    rst = 1'b1;
    #1;
    chk("async_rst_x5", {32'd0, bus.rs1_data}, 64'd0);
    chk("async_rst_x9", {32'd0, bus.rs2_data}, 64'd0);
    chk("async_rst_count", {32'd0, bus.wb_count}, 64'd0);
    drive(1'b1, 1'b1, 5'd5, 1'b0, 32'h99, 32'h0, 5'd5, 5'd9);
    @(posedge clk); #1;
    chk("rst_drop_commit", {32'd0, bus.rs1_data}, 64'd0);
    chk("rst_drop_count", {32'd0, bus.wb_count}, 64'd0);
    bus.en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the array model
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
    for (int n = 0; n < 400; n++) rand_cycle();
    bus.en = 1'b0;

    // 4-bit counter wrap: 17 commits -> 1
    for (int n = 1; n <= 17; n++) begin
      bus4.en = 1'b1; bus4.rd_wr_w = 1'b1; bus4.rd_addr_w = 5'(1 + (n % 31));
      bus4.alu_data_w = 32'(n);
      @(posedge clk); #1;
      if (n == 15) chk("wrap_cnt15", {60'd0, bus4.wb_count}, 64'd15);
      if (n == 16) chk("wrap_cnt16", {60'd0, bus4.wb_count}, 64'd0);
    end
    bus4.en = 1'b0;
    chk("wrap_cnt17", {60'd0, bus4.wb_count}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
